sd_block_read_controller: RTL
=============================

# sd_block_read_controller

Sequences a complete single-block read (CMD17) on the SD card SPI bus: it shifts out the 48-bit command, receives and checks the R1 response, hunts for the data start token, and streams 512 data bytes plus the 16-bit CRC. It sits between the game's asset loader, which requests blocks by address, and the SD SPI pins.

## Interface
Parameters:
- R1_TIMEOUT, 16: maximum SCLK cycles spent waiting for the R1 start bit.
- TOKEN_TIMEOUT, 4096: maximum bytes received while waiting for the data start token.
- BLOCK_BYTES, 512: data bytes per block.

Ports:
- CLK input 1: SD SCLK; all state updates on the falling edge.
- RST input 1: asynchronous, active-high reset.
- START input 1: request a block read; sampled only in IDLE.
- ADDR input 32: block address, latched when START is accepted.
- DO input 1: card data out (MISO).
- DI output 1: card data in (MOSI).
- CS output 1: card chip select, active low.
- BUSY output 1: high from START acceptance until DONE or ERROR completes.
- DATA_OUT output 8: last received data byte.
- DATA_VALID output 1: one-cycle pulse per data byte.
- DONE output 1: one-cycle pulse on successful completion.
- ERROR output 1: one-cycle pulse on failure.
- ERR_CODE output 2: cause of the last failure; held until the next START.

## Operation
- States: IDLE, SEND_CMD, WAIT_R1, RECV_R1, WAIT_TOKEN, RECV_DATA, RECV_CRC, FINISH, FAIL.
- IDLE: CS=1, DI=1. START=1 latches ADDR, clears ERR_CODE, and moves to SEND_CMD.
- SEND_CMD: CS=0; drives 48 bits MSB-first: 0x51, ADDR[31:0], 0xFF. Then goes to WAIT_R1.
- WAIT_R1: DI=1; counts SCLK cycles. DO=0 is the R1 start bit and moves to RECV_R1. If the count reaches R1_TIMEOUT, goes to FAIL with ERR_CODE=0.
- RECV_R1: shifts in the remaining 7 bits. R1==0x00 moves to WAIT_TOKEN. Any nonzero R1 goes to FAIL with ERR_CODE=1.
- WAIT_TOKEN: receives byte-aligned bytes.
  - 0xFE moves to RECV_DATA.
  - 0xFF increments the byte count; the count reaching TOKEN_TIMEOUT goes to FAIL with ERR_CODE=2.
  - Any other byte is an error token and goes to FAIL with ERR_CODE=2.
- RECV_DATA: BLOCK_BYTES bytes, MSB-first. On each 8th bit, DATA_OUT is updated and DATA_VALID pulses. Then goes to RECV_CRC.
- RECV_CRC: receives 16 bits, then goes to FINISH.
- FINISH: CS=1 and DI=1 for 8 cycles, then DONE pulses and the state returns to IDLE.
- FAIL: CS=1 for 8 cycles, then ERROR pulses and the state returns to IDLE.
- START asserted while BUSY=1 is ignored.

## Timing
- Reset values: CS=1, DI=1, BUSY=0, DATA_OUT=0, DATA_VALID=0, DONE=0, ERROR=0, ERR_CODE=0, state=IDLE, all counters 0.
- RST asserted mid-transfer forces the reset values immediately; there is no partial DONE or ERROR.
- DI changes on the falling edge; the card samples it on the rising edge. DO is sampled on the falling edge.
- START sampled on the falling edge k gives: CS=0 and the first command bit on DI at edge k+1; the last command bit at edge k+48.
- R1 timeout: the start bit is accepted on edges 1..R1_TIMEOUT of WAIT_R1. A start bit arriving exactly on edge R1_TIMEOUT is accepted.
- DATA_VALID and DATA_OUT update on the same edge; DATA_VALID is high for exactly one cycle.
- Bit counter: 3 bits, wraps 7→0 per byte. Byte counter: 10 bits.
- DONE goes high 8 cycles after the last CRC bit. BUSY falls on the edge where DONE or ERROR rises.
- DONE and ERROR are never high together.
- Minimum transaction length: 48 + 1 + 7 + 8 + 8·BLOCK_BYTES + 16 + 8 cycles.

## Configuration
- SD_READ_CRC_CHECK_EN defined:
  - A CRC16-CCITT (polynomial 0x1021, initial value 0) is computed serially over the data bits.
  - In RECV_CRC it is compared with the received CRC. A mismatch goes to FAIL with ERR_CODE=3 instead of FINISH.
- Undefined: the CRC bits are clocked in and discarded, and ERR_CODE=3 never occurs.

## Test plan
- Normal read: ADDR=0x00000010, card answers R1=0x00 after 3 idle bits, one 0xFF, token 0xFE, data bytes 0x00..0xFF repeated, valid CRC. Required: DI shows 0x51 00 00 00 10 FF; 512 DATA_VALID pulses in order; one DONE; ERROR=0.
- R1 timeout: DO held at 1. Required: ERROR pulses, ERR_CODE=0, CS=1, no DATA_VALID.
- R1 rejection: card answers R1=0x04. Required: ERROR, ERR_CODE=1, no WAIT_TOKEN bytes consumed.
- Error token: card sends 0x08 in place of the token. Required: ERROR, ERR_CODE=2. A separate run with DO stuck at 0xFF for 4096 bytes also gives ERR_CODE=2.
- CRC mismatch with SD_READ_CRC_CHECK_EN: flip one CRC bit. Required: 512 DATA_VALID pulses, then ERROR with ERR_CODE=3. Without the macro: DONE.
- Reset mid-data: assert RST after byte 100. Required: CS=1, BUSY=0, no DONE or ERROR. A following START completes normally.

Source files
------------

// File: rtl/sd_block_read_controller_if.sv
// Bundles the asset-loader request/status signals and the SD SPI pins for
// sd_block_read_controller.
//   start, addr       : block read request and block address
//   busy              : transaction in progress
//   data_out, data_valid : received data byte and its one-cycle strobe
//   done, error       : one-cycle completion / failure pulses
//   err_code          : cause of the last failure (0 R1 timeout, 1 R1 reject,
//                       2 token error/timeout, 3 CRC mismatch)
//   card_do           : card data out (MISO)
//   card_di, cs       : card data in (MOSI) and active-low chip select
// Modports: master = the controller (it drives the SPI bus),
//           slave  = the environment (loader plus card).
interface sd_block_read_controller_if;
  logic        start;
  logic [31:0] addr;
  logic        card_do;
  logic        card_di;
  logic        cs;
  logic        busy;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  modport master (
    input  start, addr, card_do,
    output card_di, cs, busy, data_out, data_valid, done, error, err_code
  );

  modport slave (
    output start, addr, card_do,
    input  card_di, cs, busy, data_out, data_valid, done, error, err_code
  );
endinterface

// File: rtl/sd_block_read_controller.sv
// Single-block read (CMD17) sequencer for an SD card on the SPI bus.
// Sends the 48-bit command, checks R1, hunts for the 0xFE start token, then
// streams BLOCK_BYTES data bytes and the 16-bit CRC.
// Ports:
//   clk : SD SCLK; all state changes on the falling edge
//   rst : asynchronous active-high reset
//   bus : sd_block_read_controller_if.master (request, status, SPI pins)
// Optional feature: define SD_READ_CRC_CHECK_EN to check the data CRC16-CCITT
// (poly 0x1021, init 0) and fail with err_code 3 on mismatch. Without it the
// CRC bits are clocked in and dropped.
module sd_block_read_controller #(
  parameter int unsigned R1_TIMEOUT    = 16,
  parameter int unsigned TOKEN_TIMEOUT = 4096,
  parameter int unsigned BLOCK_BYTES   = 512
) (
  input logic                        clk,
  input logic                        rst,
  sd_block_read_controller_if.master bus
);

  localparam int unsigned WaitMax = (TOKEN_TIMEOUT > R1_TIMEOUT) ? TOKEN_TIMEOUT : R1_TIMEOUT;
  // One shared counter covers command bits, R1 wait, token wait, CRC bits and tail.
  localparam int unsigned CntW = $clog2(WaitMax + 64);

  localparam logic [CntW-1:0] CmdLast  = CntW'(47);
  localparam logic [CntW-1:0] CrcLast  = CntW'(15);
  localparam logic [CntW-1:0] TailLast = CntW'(7);
  localparam logic [CntW-1:0] R1Last   = CntW'(R1_TIMEOUT - 1);
  localparam logic [CntW-1:0] TokLast  = CntW'(TOKEN_TIMEOUT - 1);
  localparam logic [9:0]      LastByte = 10'(BLOCK_BYTES - 1);

  typedef enum logic [3:0] {
    StIdle, StSendCmd, StWaitR1, StRecvR1, StWaitToken, StRecvData, StRecvCrc, StFinish, StFail
  } state_e;

  state_e          state_q;
  logic [47:0]     cmd_q;
  logic [6:0]      rx_q;
  logic [2:0]      bit_cnt_q;
  logic [9:0]      byte_cnt_q;
  logic [CntW-1:0] cnt_q;
  logic            cs_q, di_q, busy_q, data_valid_q, done_q, error_q;
  logic [7:0]      data_out_q;
  logic [1:0]      err_code_q;
  logic [7:0]      rx_byte;
`ifdef SD_READ_CRC_CHECK_EN
  logic [15:0]     crc_q;
  logic [15:0]     crc_rx_q;
  logic            crc_fb;
  assign crc_fb = crc_q[15] ^ bus.card_do;
`endif

  // Byte completed by the bit arriving on this edge.
  assign rx_byte = {rx_q, bus.card_do};

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cmd_q        <= '0;
      rx_q         <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      cnt_q        <= '0;
      cs_q         <= 1'b1;
      di_q         <= 1'b1;
      busy_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= '0;
`ifdef SD_READ_CRC_CHECK_EN
      crc_q        <= '0;
      crc_rx_q     <= '0;
`endif
    end else begin
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cs_q <= 1'b1;
          di_q <= 1'b1;
          if (bus.start) begin
            cmd_q      <= {8'h51, bus.addr, 8'hFF};
            err_code_q <= '0;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
`ifdef SD_READ_CRC_CHECK_EN
            crc_q      <= '0;
`endif
            state_q    <= StSendCmd;
          end
        end
        StSendCmd: begin
          cs_q  <= 1'b0;
          di_q  <= cmd_q[47];
          cmd_q <= {cmd_q[46:0], 1'b1};
          if (cnt_q == CmdLast) begin
            cnt_q   <= '0;
            state_q <= StWaitR1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitR1: begin
          di_q <= 1'b1;
          if (!bus.card_do) begin
            // The start bit is R1[7]; it lands in rx_q as a leading zero.
            rx_q      <= '0;
            bit_cnt_q <= '0;
            cnt_q     <= '0;
            state_q   <= StRecvR1;
          end else if (cnt_q == R1Last) begin
            cs_q       <= 1'b1;
            cnt_q      <= '0;
            err_code_q <= 2'd0;
            state_q    <= StFail;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRecvR1: begin
          rx_q <= rx_byte[6:0];
          if (bit_cnt_q == 3'd6) begin
            bit_cnt_q <= '0;
            cnt_q     <= '0;
            if (rx_byte == 8'h00) begin
              state_q <= StWaitToken;
            end else begin
              cs_q       <= 1'b1;
              err_code_q <= 2'd1;
              state_q    <= StFail;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        StWaitToken: begin
          rx_q      <= rx_byte[6:0];
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            if (rx_byte == 8'hFE) begin
              byte_cnt_q <= '0;
              state_q    <= StRecvData;
            end else if (rx_byte == 8'hFF && cnt_q != TokLast) begin
              cnt_q <= cnt_q + 1'b1;
            end else begin
              cs_q       <= 1'b1;
              cnt_q      <= '0;
              err_code_q <= 2'd2;
              state_q    <= StFail;
            end
          end
        end
        StRecvData: begin
          rx_q      <= rx_byte[6:0];
          bit_cnt_q <= bit_cnt_q + 1'b1;
`ifdef SD_READ_CRC_CHECK_EN
          crc_q <= {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
`endif
          if (bit_cnt_q == 3'd7) begin
            data_out_q   <= rx_byte;
            data_valid_q <= 1'b1;
            if (byte_cnt_q == LastByte) begin
              byte_cnt_q <= '0;
              cnt_q      <= '0;
              state_q    <= StRecvCrc;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        StRecvCrc: begin
`ifdef SD_READ_CRC_CHECK_EN
          crc_rx_q <= {crc_rx_q[14:0], bus.card_do};
`endif
          if (cnt_q == CrcLast) begin
            cnt_q   <= '0;
            cs_q    <= 1'b1;
            di_q    <= 1'b1;
`ifdef SD_READ_CRC_CHECK_EN
            if ({crc_rx_q[14:0], bus.card_do} != crc_q) begin
              err_code_q <= 2'd3;
              state_q    <= StFail;
            end else begin
              state_q <= StFinish;
            end
`else
            state_q <= StFinish;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFinish, StFail: begin
          cs_q <= 1'b1;
          di_q <= 1'b1;
          if (cnt_q == TailLast) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= (state_q == StFinish);
            error_q <= (state_q == StFail);
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cs         = cs_q;
  assign bus.card_di    = di_q;
  assign bus.busy       = busy_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.err_code   = err_code_q;

endmodule
